// File: rtl/exc_request.sv
`default_nettype none
// ============================================================================
// exc_request : LEGv8 exception initiator, prioritised Exc/EStatus handshake
// Revision    : 1.0
// ============================================================================
module exc_request #(
    parameter int CNT_W    = 8,
    parameter int IRQ_SYNC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             badop_D,
    input  logic             valid_D,
    input  logic             trap_D,
    input  logic             ext_irq,
    input  logic             irq_en,
    input  logic             ExcAck,
    input  logic             ERet,
    output logic             Exc,
    output logic [3:0]       EStatus,
    output logic             in_handler,
    output logic [CNT_W-1:0] exc_cnt
);

    localparam logic [3:0]       CODE_NONE = 4'b0000;
    localparam logic [3:0]       CODE_IRQ  = 4'b0001;
    localparam logic [3:0]       CODE_OP   = 4'b0010;
    localparam logic [3:0]       CODE_TRAP = 4'b0011;
    localparam logic [3:0]       CODE_DF   = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state;
    logic [IRQ_SYNC-1:0] irq_sync;
    logic                irq_prev;
    logic                pend_op;
    logic                pend_trap;
    logic                pend_irq;
    logic                pend_df;

    logic                ev_op;
    logic                ev_trap;
    logic                ev_irq;
    logic                avail_op;
    logic                avail_trap;
    logic                avail_irq;
    logic                sel_df;
    logic                sel_op;
    logic                sel_trap;
    logic                sel_irq;
    logic [3:0]          sel_code;

    // Selection sees both sticky pending bits and this cycle's events, so a
    // decode event in IDLE raises Exc after a single edge.
    always_comb begin
        ev_op      = valid_D & badop_D;
        ev_trap    = valid_D & trap_D;
        ev_irq     = irq_sync[IRQ_SYNC-1] & ~irq_prev & irq_en;
        avail_op   = pend_op | ev_op;
        avail_trap = pend_trap | ev_trap;
        avail_irq  = (pend_irq | ev_irq) & irq_en;
        sel_df     = 1'b0;
        sel_op     = 1'b0;
        sel_trap   = 1'b0;
        sel_irq    = 1'b0;
        sel_code   = CODE_NONE;
        if (pend_df) begin
            sel_df   = 1'b1;
            sel_code = CODE_DF;
        end else if (avail_op) begin
            sel_op   = 1'b1;
            sel_code = CODE_OP;
        end else if (avail_trap) begin
            sel_trap = 1'b1;
            sel_code = CODE_TRAP;
        end else if (avail_irq) begin
            sel_irq  = 1'b1;
            sel_code = CODE_IRQ;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            irq_sync   <= '0;
            irq_prev   <= 1'b0;
            pend_op    <= 1'b0;
            pend_trap  <= 1'b0;
            pend_irq   <= 1'b0;
            pend_df    <= 1'b0;
            Exc        <= 1'b0;
            EStatus    <= CODE_NONE;
            in_handler <= 1'b0;
            exc_cnt    <= '0;
        end else begin
            irq_sync <= {irq_sync[IRQ_SYNC-2:0], ext_irq};
            irq_prev <= irq_sync[IRQ_SYNC-1];

            // An invalid opcode inside the handler is recorded as a double fault only.
            if (ev_op && state == SERVICE) pend_df <= 1'b1;
            if (ev_op && state != SERVICE) pend_op <= 1'b1;
            if (ev_trap)                   pend_trap <= 1'b1;
            if (ev_irq)                    pend_irq <= 1'b1;

            case (state)
                IDLE: begin
                    if (sel_df || sel_op || sel_trap || sel_irq) begin
                        state   <= PEND;
                        Exc     <= 1'b1;
                        EStatus <= sel_code;
                        if (sel_df)   pend_df   <= 1'b0;
                        if (sel_op)   pend_op   <= 1'b0;
                        if (sel_trap) pend_trap <= 1'b0;
                        if (sel_irq)  pend_irq  <= 1'b0;
                    end
                end
                PEND: begin
                    if (ExcAck) begin
                        state      <= SERVICE;
                        Exc        <= 1'b0;
                        in_handler <= 1'b1;
                        if (exc_cnt != CNT_MAX) exc_cnt <= exc_cnt + CNT_ONE;
                    end
                end
                SERVICE: begin
                    if (ERet) begin
                        state      <= IDLE;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Exc   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_request.sv
`default_nettype none
// tb_exc_request : directed self-checking bench for exc_request.
module tb_exc_request;

    logic       clk = 1'b0;
    logic       reset;
    logic       badop_D, valid_D, trap_D, ext_irq, irq_en, ExcAck, ERet;
    logic       Exc, in_handler;
    logic [3:0] EStatus;
    logic [7:0] exc_cnt;
    logic       Exc2, in_handler2;
    logic [3:0] EStatus2;
    logic [1:0] exc_cnt2;

    int errors = 0;
    int checks = 0;
    logic seen;

    always #5 clk = ~clk;

    exc_request #(.CNT_W(8), .IRQ_SYNC(2)) dut (
        .clk(clk), .reset(reset), .badop_D(badop_D), .valid_D(valid_D),
        .trap_D(trap_D), .ext_irq(ext_irq), .irq_en(irq_en), .ExcAck(ExcAck),
        .ERet(ERet), .Exc(Exc), .EStatus(EStatus), .in_handler(in_handler),
        .exc_cnt(exc_cnt)
    );

    exc_request #(.CNT_W(2), .IRQ_SYNC(2)) dut_sat (
        .clk(clk), .reset(reset), .badop_D(badop_D), .valid_D(valid_D),
        .trap_D(trap_D), .ext_irq(ext_irq), .irq_en(irq_en), .ExcAck(ExcAck),
        .ERet(ERet), .Exc(Exc2), .EStatus(EStatus2), .in_handler(in_handler2),
        .exc_cnt(exc_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack();
        ExcAck = 1'b1; step(); ExcAck = 1'b0;
    endtask

    task automatic eret();
        ERet = 1'b1; step(); ERet = 1'b0;
    endtask

    initial begin
        reset = 1'b0; badop_D = 0; valid_D = 0; trap_D = 0;
        ext_irq = 0; irq_en = 0; ExcAck = 0; ERet = 0;
        #12;
        chk("rst_exc", Exc, 0);
        chk("rst_estatus", EStatus, 0);
        chk("rst_inh", in_handler, 0);
        chk("rst_cnt", exc_cnt, 0);
        step();
        reset = 1'b1;
        step();

        // Invalid opcode, one-edge latency, held until acknowledged
        valid_D = 1; badop_D = 1; step(); valid_D = 0; badop_D = 0;
        chk("op_exc", Exc, 1);
        chk("op_code", EStatus, 4'b0010);
        step(); step();
        chk("op_hold_exc", Exc, 1);
        chk("op_hold_code", EStatus, 4'b0010);
        ack();
        chk("op_ack_exc", Exc, 0);
        chk("op_ack_inh", in_handler, 1);
        chk("op_ack_cnt", exc_cnt, 1);
        step();
        eret();
        chk("op_eret_inh", in_handler, 0);
        chk("op_eret_code_hold", EStatus, 4'b0010);

        // ExcAck in IDLE is ignored
        ack();
        chk("idle_ack_exc", Exc, 0);
        chk("idle_ack_inh", in_handler, 0);
        chk("idle_ack_cnt", exc_cnt, 1);

        // IRQ: Exc appears IRQ_SYNC+1 edges after the line rises
        irq_en = 1; ext_irq = 1;
        step(); chk("irq_lat1", Exc, 0);
        step(); chk("irq_lat2", Exc, 0);
        step(); chk("irq_lat3", Exc, 1);
        chk("irq_code", EStatus, 4'b0001);
        ack(); chk("irq_cnt", exc_cnt, 2);
        eret();
        seen = 0;
        for (int i = 0; i < 10; i++) begin step(); seen = seen | Exc; end
        chk("irq_level_once", seen, 0);
        ext_irq = 0; step(); step(); step();

        // Arbitration: op, trap and irq edge in the same cycle
        ext_irq = 1; step(); step();
        valid_D = 1; badop_D = 1; trap_D = 1; step();
        valid_D = 0; badop_D = 0; trap_D = 0;
        chk("arb1_exc", Exc, 1);
        chk("arb1_code", EStatus, 4'b0010);
        ack(); eret();
        chk("arb_idle_gap", Exc, 0);
        step();
        chk("arb2_exc", Exc, 1);
        chk("arb2_code", EStatus, 4'b0011);
        ack(); eret(); step();
        chk("arb3_exc", Exc, 1);
        chk("arb3_code", EStatus, 4'b0001);
        ack();
        chk("arb_cnt", exc_cnt, 5);
        chk("sat_cnt", exc_cnt2, 3);
        eret();
        ext_irq = 0; step(); step(); step();

        // Masked interrupt edge leaves no request
        irq_en = 0; ext_irq = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin step(); seen = seen | Exc; end
        irq_en = 1;
        for (int i = 0; i < 4; i++) begin step(); seen = seen | Exc; end
        chk("mask_no_exc", seen, 0);
        ext_irq = 0; step(); step(); step();

        // Double fault: badop during SERVICE
        valid_D = 1; trap_D = 1; step(); valid_D = 0; trap_D = 0;
        chk("df_trap_code", EStatus, 4'b0011);
        ack();
        valid_D = 1; badop_D = 1; step(); valid_D = 0; badop_D = 0;
        eret();
        chk("df_idle_gap", Exc, 0);
        step();
        chk("df_exc", Exc, 1);
        chk("df_code", EStatus, 4'b1111);
        ack();
        chk("df_cnt", exc_cnt, 7);
        eret();
        seen = 0;
        for (int i = 0; i < 3; i++) begin step(); seen = seen | Exc; end
        chk("df_no_extra_op", seen, 0);

        // Async reset mid-PEND, with a trap left pending behind the opcode
        valid_D = 1; badop_D = 1; trap_D = 1; step();
        valid_D = 0; badop_D = 0; trap_D = 0;
        chk("ar_pend_exc", Exc, 1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("ar_exc", Exc, 0);
        chk("ar_code", EStatus, 0);
        chk("ar_cnt", exc_cnt, 0);
        chk("ar_inh", in_handler, 0);
        chk("ar_cnt_sat", exc_cnt2, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin step(); seen = seen | Exc; end
        chk("ar_pending_cleared", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
